// File: rtl/seven_segment_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_capture_if
// Purpose  : Captured-word handshake bundle between the capture block and its consumer.
// Revision : 1.0
// ============================================================================
interface seven_segment_capture_if;
    logic [15:0] value;
    logic        valid;
    logic        ack;
    logic        err;
    logic        overrun;
    logic [7:0]  err_count;

    modport master (
        output value,
        output valid,
        output err,
        output overrun,
        output err_count,
        input  ack
    );

    modport slave (
        input  value,
        input  valid,
        input  err,
        input  overrun,
        input  err_count,
        output ack
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_capture
// Purpose  : Decodes a multiplexed active-low seven-segment bus back into the
//            16-bit displayed word; optional undecodable-sample counter is
//            enabled by defining SEG_CAPTURE_ERRCNT_EN.
// Revision : 1.0
// ============================================================================
module seven_segment_capture #(
    parameter int SETTLE = 4
) (
    input  wire                        clk,
    input  wire                        rst,
    input  wire [6:0]                  LED_out,
    input  wire                        d0,
    input  wire                        d1,
    input  wire                        d2,
    input  wire                        d3,
    seven_segment_capture_if.master    bus
);

    localparam logic [7:0] c_settle = 8'(SETTLE);

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_SETTLE = 2'd1,
        S_HELD   = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_sel;
    logic [6:0]  r_led;
    logic [3:0]  r_dig;
    logic [15:0] r_shadow;
    logic [3:0]  r_mask;
    logic        r_ferr;
    logic [15:0] r_value;
    logic        r_valid;
    logic        r_err;
    logic        r_overrun;

    logic        w_sel_valid;
    logic [1:0]  w_idx;
    logic [3:0]  w_bit;
    logic [3:0]  w_nib;
    logic        w_bad;
    logic        w_same;
    logic        w_sample;
    logic        w_complete;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led <= 7'h7F;
            r_dig <= 4'hF;
        end else begin
            r_led <= LED_out;
            r_dig <= {d3, d2, d1, d0};
        end
    end

    always_comb begin
        w_sel_valid = 1'b1;
        w_idx       = 2'd0;
        case (r_dig)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_sel_valid = 1'b0;
        endcase
    end

    assign w_bit = 4'b0001 << w_idx;

    always_comb begin
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (r_led)
            7'b0000001: w_nib = 4'h0;
            7'b1001111: w_nib = 4'h1;
            7'b0010010: w_nib = 4'h2;
            7'b0000110: w_nib = 4'h3;
            7'b1001100: w_nib = 4'h4;
            7'b0100100: w_nib = 4'h5;
            7'b0100000: w_nib = 4'h6;
            7'b0001111: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0000100: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b1100000: w_nib = 4'hB;
            7'b0110001: w_nib = 4'hC;
            7'b1000010: w_nib = 4'hD;
            7'b0110000: w_nib = 4'hE;
            7'b0111000: w_nib = 4'hF;
            default:    w_bad = 1'b1;
        endcase
    end

    assign w_same     = (r_dig == r_sel);
    assign w_sample   = (r_state == S_SETTLE) && w_same && (r_cnt == c_settle);
    assign w_complete = (r_mask == 4'hF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BLANK;
            r_cnt   <= 8'd0;
            r_sel   <= 4'hF;
        end else begin
            case (r_state)
                S_BLANK: begin
                    if (w_sel_valid) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= 8'd1;
                        r_sel   <= r_dig;
                    end
                end
                S_SETTLE: begin
                    if (w_same) begin
                        if (r_cnt == c_settle) begin
                            r_state <= S_HELD;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else if (w_sel_valid) begin
                        r_cnt <= 8'd1;
                        r_sel <= r_dig;
                    end else begin
                        r_state <= S_BLANK;
                        r_cnt   <= 8'd0;
                    end
                end
                S_HELD: begin
                    if (!w_same) begin
                        if (w_sel_valid) begin
                            r_state <= S_SETTLE;
                            r_cnt   <= 8'd1;
                            r_sel   <= r_dig;
                        end else begin
                            r_state <= S_BLANK;
                            r_cnt   <= 8'd0;
                        end
                    end
                end
                default: begin
                    r_state <= S_BLANK;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // A completed mask is consumed on the edge after it fills, even if a new sample lands then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow  <= 16'h0000;
            r_mask    <= 4'h0;
            r_ferr    <= 1'b0;
            r_value   <= 16'h0000;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_mask <= (w_complete ? 4'h0 : r_mask) | (w_sample ? w_bit : 4'h0);
            r_ferr <= (w_complete ? 1'b0 : r_ferr) | (w_sample & w_bad);
            if (w_sample) begin
                r_shadow[{w_idx, 2'b00} +: 4] <= w_nib;
            end
            if (w_complete && (!r_valid || bus.ack)) begin
                r_value   <= r_shadow;
                r_err     <= r_ferr;
                r_valid   <= 1'b1;
                r_overrun <= 1'b0;
            end else if (w_complete) begin
                r_overrun <= 1'b1;
            end else if (bus.ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.value   = r_value;
    assign bus.valid   = r_valid;
    assign bus.err     = r_err;
    assign bus.overrun = r_overrun;

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= 8'd0;
        end else if (w_sample && w_bad && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_capture
// Purpose  : Scoreboarded bench driving a model multiplexed display into the capture block.
// Revision : 1.0
// ============================================================================
module tb_seven_segment_capture;

`ifdef SEG_CAPTURE_ERRCNT_EN
    localparam int c_exp_errcnt = 1;
`else
    localparam int c_exp_errcnt = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] LED_out = 7'h7F;
    logic       d0 = 1'b1;
    logic       d1 = 1'b1;
    logic       d2 = 1'b1;
    logic       d3 = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] sb_q[$];
    logic        prev_valid = 1'b0;

    seven_segment_capture_if bus ();

    seven_segment_capture #(.SETTLE(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .LED_out (LED_out),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] sel(input int idx);
        logic [3:0] one;
        one = 4'b0001 << idx;
        return ~one;
    endfunction

    task automatic show(input logic [3:0] dl, input logic [6:0] seg, input int n);
        {d3, d2, d1, d0} = dl;
        LED_out = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] v);
        for (int i = 0; i < 4; i++) show(sel(i), seg_of(v[i*4 +: 4]), 20);
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Output side of the scoreboard: every rising valid consumes one expected frame.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst && bus.valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_frame", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("frame_value", 32'(bus.value), 32'(e[15:0]));
                check_eq("frame_err", 32'(bus.err), 32'(e[16]));
            end
        end
        prev_valid = bus.valid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_value", 32'(bus.value), 32'd0);
        check_eq("rst_valid", 32'(bus.valid), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
        check_eq("rst_errcnt", 32'(bus.err_count), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Normal frame
        sb_q.push_back({1'b0, 16'h123F});
        scan(16'h123F);
        wait_drain("drain_123f");
        check_eq("normal_valid", 32'(bus.valid), 32'd1);

        // Second scan without ack -> overrun, value held
        scan(16'h4567);
        check_eq("ovr_value", 32'(bus.value), 32'h123F);
        check_eq("ovr_flag", 32'(bus.overrun), 32'd1);
        pulse_ack();
        check_eq("ack_valid", 32'(bus.valid), 32'd0);
        check_eq("ack_overrun", 32'(bus.overrun), 32'd0);

        sb_q.push_back({1'b0, 16'h89AB});
        scan(16'h89AB);
        wait_drain("drain_89ab");
        check_eq("rescan_valid", 32'(bus.valid), 32'd1);
        pulse_ack();

        // Settle filter: 4-cycle d2 must not sample, 5-cycle d2 must
        show(4'hF, 7'h7F, 10);
        show(sel(2), seg_of(4'h2), 4);
        show(4'hF, 7'h7F, 10);
        show(sel(0), seg_of(4'h5), 20);
        show(4'hF, 7'h7F, 5);
        show(sel(1), seg_of(4'h6), 20);
        show(4'hF, 7'h7F, 5);
        show(sel(3), seg_of(4'h7), 20);
        show(4'hF, 7'h7F, 10);
        check_eq("short_select", 32'(bus.valid), 32'd0);
        sb_q.push_back({1'b0, 16'h7265});
        show(sel(2), seg_of(4'h2), 5);
        show(4'hF, 7'h7F, 10);
        wait_drain("drain_settle");
        pulse_ack();

        // Double select is blank; bad pattern yields err and zero nibble
        show(4'b1001, seg_of(4'h8), 20);
        show(4'hF, 7'h7F, 5);
        show(sel(0), seg_of(4'h9), 20);
        show(sel(2), seg_of(4'hC), 20);
        show(sel(3), seg_of(4'h7), 20);
        show(4'hF, 7'h7F, 10);
        check_eq("double_select", 32'(bus.valid), 32'd0);
        sb_q.push_back({1'b1, 16'h7C09});
        show(sel(1), 7'b1111111, 20);
        show(4'hF, 7'h7F, 10);
        wait_drain("drain_bad");
        check_eq("err_count", 32'(bus.err_count), 32'(c_exp_errcnt));
        pulse_ack();

        // Reset mid-frame discards the partial capture
        show(sel(0), seg_of(4'hD), 20);
        show(sel(1), seg_of(4'hC), 20);
        rst = 1'b0;
        #1;
        check_eq("midrst_value", 32'(bus.value), 32'd0);
        check_eq("midrst_err", 32'(bus.err), 32'd0);
        check_eq("midrst_errcnt", 32'(bus.err_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb_q.push_back({1'b0, 16'hABCD});
        scan(16'hABCD);
        wait_drain("drain_abcd");

        // Simultaneous ack and frame completion
        scan(16'h1111);
        check_eq("pre_sim_overrun", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 3; i++) show(sel(i), seg_of(4'hE - 4'(i)), 20);
        show(sel(3), seg_of(4'h0), 6);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check_eq("sim_valid", 32'(bus.valid), 32'd1);
        check_eq("sim_value", 32'(bus.value), 32'h0CDE);
        check_eq("sim_overrun", 32'(bus.overrun), 32'd0);
        show(sel(3), seg_of(4'h0), 13);
        pulse_ack();
        check_eq("final_valid", 32'(bus.valid), 32'd0);
        wait_drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
